code_avg_fifo: RTL

//  Downstream of the digital control core: consumes its WIDTH-bit thermometer/binary output code,

---
 rtl/code_avg_pkg.sv | 13 +
 rtl/code_fifo.sv | 49 ++++
 rtl/code_avg_fifo.sv | 90 +++++++++
 3 files changed

// File: rtl/code_avg_pkg.sv
// code_avg_pkg: shared types, default sizes and width helpers for the code averaging FIFO
package code_avg_pkg;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_AVG_LOG2 = 2;
  localparam int DEF_DEPTH = 4;
  typedef enum logic {ACC, PUSH} avg_state_e;
  function automatic int acc_w(input int width, input int avg_log2);
    return width + avg_log2;
  endfunction
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/code_fifo.sv
// code_fifo: first-word-fall-through FIFO with sync clear; ports clk, rst_n, clear, push/din, pop/dout, full, empty, level
module code_fifo
  import code_avg_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic                      push,
  input  logic [WIDTH-1:0]          din,
  input  logic                      pop,
  output logic [WIDTH-1:0]          dout,
  output logic                      full,
  output logic                      empty,
  output logic [lvl_w(DEPTH)-1:0]   level
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = lvl_w(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = level == LW'(DEPTH);
  assign empty = level == '0;
  // a push into a full FIFO is accepted only when a pop frees a slot in the same cycle
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // head is forced to zero while empty so the output never shows stale or unwritten storage
  assign dout = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end
endmodule

// File: rtl/code_avg_fifo.sv
// code_avg_fifo: averages 2**AVG_LOG2 code samples and queues the results; ports clk, rst_n, clear, in_code/in_valid, out_data/out_valid/out_ready, level, overflow; CODE_AVG_ROUND_EN selects round-half-up with saturation instead of truncation
module code_avg_fifo
  import code_avg_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AVG_LOG2 = DEF_AVG_LOG2,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic [WIDTH-1:0]          in_code,
  input  logic                      in_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [lvl_w(DEPTH)-1:0]   level,
  output logic                      overflow
);
  localparam int AW = acc_w(WIDTH, AVG_LOG2);
  avg_state_e state, state_n;
  logic [AW-1:0] acc, acc_n;
  logic [AVG_LOG2-1:0] cnt, cnt_n;
  logic ovf_n, push, full, empty, pop;
  logic [WIDTH-1:0] result;
`ifdef CODE_AVG_ROUND_EN
  logic [AW:0] rsum;
  logic [WIDTH:0] rq;
  assign rsum = {1'b0, acc} + (AW+1)'(2 ** (AVG_LOG2 - 1));
  assign rq = rsum[AW:AVG_LOG2];
  assign result = rq[WIDTH] ? '1 : rq[WIDTH-1:0];
`else
  assign result = acc[AW-1:AVG_LOG2];
`endif
  assign out_valid = !empty;
  assign pop = out_valid && out_ready;
  always_comb begin
    state_n = state;
    acc_n = acc;
    cnt_n = cnt;
    ovf_n = overflow;
    push = 1'b0;
    if (state == ACC) begin
      if (in_valid) begin
        acc_n = acc + AW'(in_code);
        cnt_n = cnt + 1'b1;
        state_n = (cnt == '1) ? PUSH : ACC;
      end
    end else begin
      push = 1'b1;
      ovf_n = overflow || (full && !pop);
      // a sample arriving during the write cycle opens the next group
      acc_n = in_valid ? AW'(in_code) : '0;
      cnt_n = AVG_LOG2'(in_valid);
      state_n = ACC;
    end
    if (clear) begin
      state_n = ACC;
      acc_n = '0;
      cnt_n = '0;
      ovf_n = 1'b0;
      push = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACC;
      acc <= '0;
      cnt <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_n;
      acc <= acc_n;
      cnt <= cnt_n;
      overflow <= ovf_n;
    end
  end
  code_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .push  (push),
    .din   (result),
    .pop   (pop),
    .dout  (out_data),
    .full  (full),
    .empty (empty),
    .level (level)
  );
endmodule
